// File: rtl/tc_slot_arbiter.sv
// tc_slot_arbiter: round-robin time-slot arbiter with
// fixed-length grants, early release and a guard gap.
package tc_slot_arbiter_pkg;

  // Counter width so that the MSB becomes the terminal count.
  function automatic int tcbits(input int len);
    return $clog2(len) + 1;
  endfunction

  // Start value so the MSB rises after exactly len increments.
  function automatic int tcstop(input int width, input int len);
    return (1 << (width - 1)) - len;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

endpackage

module tc_slot_arbiter
  import tc_slot_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SLOT_LEN = 16,
  parameter int GAP_LEN  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         release_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic                    busy_o,
  output logic                    slot_end_o
);

  localparam int IW = $clog2(NREQ);
  localparam int ML0 =
    (SLOT_LEN > GAP_LEN) ? SLOT_LEN : GAP_LEN;
  localparam int MAXL = (ML0 > 1) ? ML0 : 1;
  localparam int CW = tcbits(MAXL);
  // A zero gap never loads the counter; keep the
  // constant well-formed anyway.
  localparam int GAPL = (GAP_LEN > 0) ? GAP_LEN : 1;

  localparam logic [CW-1:0] SLOT_STOP =
    CW'(tcstop(CW, SLOT_LEN));
  localparam logic [CW-1:0] GAP_STOP =
    CW'(tcstop(CW, GAPL));
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            tc;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win;
  logic            found;
  logic            rel_hit;

  assign cnt_nxt = cnt + CW'(1);
  assign tc      = cnt_nxt[CW-1];
  assign rel_hit = release_i[grant_idx_o];
  assign busy_o  = (state != ST_IDLE);

  // Rotating priority search starting just after the last owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Slot/gap sequencer with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant_o     <= '0;
      grant_idx_o <= '0;
      slot_end_o  <= 1'b0;
      ptr         <= PTR_RST;
      cnt         <= '0;
    end else begin
      slot_end_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            state       <= ST_GRANT;
            grant_o     <= NREQ'(1) << win;
            grant_idx_o <= win;
            ptr         <= win;
            cnt         <= SLOT_STOP;
          end
        end
        ST_GRANT: begin
          if (tc || rel_hit) begin
            grant_o    <= '0;
            slot_end_o <= 1'b1;
            if (GAP_LEN > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_STOP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ST_GAP: begin
          cnt <= cnt_nxt;
          if (tc) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_slot_arbiter.sv
// tb_tc_slot_arbiter: directed vectors for the
// time-slot arbiter, default and minimal-slot builds.
module tb_tc_slot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] grant;
  logic [1:0] idx;
  logic       busy;
  logic       se;

  logic [3:0] req6;
  logic [3:0] rel6;
  logic [3:0] grant6;
  logic [1:0] idx6;
  logic       busy6;
  logic       se6;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] rel;
    int         n;
    logic [3:0] g;
    logic [1:0] idx;
    bit         busy;
    bit         se;
  } vec_t;

  vec_t tbl[$];

  tc_slot_arbiter #(
    .NREQ(4), .SLOT_LEN(16), .GAP_LEN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .release_i(rel),
    .grant_o(grant), .grant_idx_o(idx),
    .busy_o(busy), .slot_end_o(se)
  );

  tc_slot_arbiter #(
    .NREQ(4), .SLOT_LEN(1), .GAP_LEN(0)
  ) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req_i(req6), .release_i(rel6),
    .grant_o(grant6), .grant_idx_o(idx6),
    .busy_o(busy6), .slot_end_o(se6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h",
                  nm, act, exp);
  endtask

  task automatic add(input bit rst,
                     input logic [3:0] rq,
                     input logic [3:0] rl,
                     input int n,
                     input logic [3:0] g,
                     input int ix,
                     input bit b,
                     input bit s);
    vec_t v;
    v.rst  = rst;
    v.req  = rq;
    v.rel  = rl;
    v.n    = n;
    v.g    = g;
    v.idx  = 2'(ix);
    v.busy = b;
    v.se   = s;
    tbl.push_back(v);
  endtask

  // Gap after a default slot: slot_end, one more gap, idle.
  task automatic add_gap(input logic [3:0] rq,
                         input int ix);
    add(0, rq, 4'b0, 1, 4'b0, ix, 1, 1);
    add(0, rq, 4'b0, 1, 4'b0, ix, 1, 0);
    add(0, rq, 4'b0, 1, 4'b0, ix, 0, 0);
  endtask

  // Asserts reset between edges and checks it acts at once.
  task automatic do_reset(input string nm);
    req   = '0;
    rel   = '0;
    req6  = '0;
    rel6  = '0;
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_grant"}, 32'(grant), 0);
    chk({nm, "_rst_idx"}, 32'(idx), 0);
    chk({nm, "_rst_busy"}, 32'(busy), 0);
    chk({nm, "_rst_se"}, 32'(se), 0);
    chk({nm, "_rst_grant6"}, 32'(grant6), 0);
    chk({nm, "_rst_busy6"}, 32'(busy6), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    string      nm;
    int         o;
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    req       = '0;
    rel       = '0;
    req6      = '0;
    rel6      = '0;

    // T1: single requester, repeating 16-on / 3-off.
    add(1, 4'b0001, 4'b0, 16, 4'b0001, 0, 1, 0);
    add_gap(4'b0001, 0);
    add(0, 4'b0001, 4'b0, 16, 4'b0001, 0, 1, 0);
    add_gap(4'b0001, 0);
    // T2: all requesting, order 0,1,2,3,0.
    for (int r = 0; r < 4; r++) begin
      g = 4'(1 << r);
      add(r == 0, 4'b1111, 4'b0, 16, g, r, 1, 0);
      add_gap(4'b1111, r);
    end
    add(0, 4'b1111, 4'b0, 16, 4'b0001, 0, 1, 0);
    // T3: owner 1 releases during its 5th cycle.
    add(1, 4'b0010, 4'b0, 5, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 1, 4'b0, 1, 1, 1);
    add(0, 4'b0000, 4'b0010, 1, 4'b0, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 3, 4'b0, 1, 0, 0);
    // T4: foreign release and dropped request ignored.
    add(1, 4'b0010, 4'b0, 3, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 4'b0100, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 12, 4'b0010, 1, 1, 0);
    add_gap(4'b0000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      for (int k = 0; k < tbl[i].n; k++) begin
        req = tbl[i].req;
        rel = tbl[i].rel;
        @(posedge clk);
        #1;
        nm = $sformatf("v%0d_%0d", i, k);
        chk({nm, "_grant"}, 32'(grant), 32'(tbl[i].g));
        chk({nm, "_idx"}, 32'(idx), 32'(tbl[i].idx));
        chk({nm, "_busy"}, 32'(busy), 32'(tbl[i].busy));
        chk({nm, "_se"}, 32'(se), 32'(tbl[i].se));
      end
    end

    // T5: async reset on grant cycle 7, then pointer restart.
    do_reset("t5a");
    req = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t5_g%0d", k), 32'(grant), 32'h1);
    end
    #1;
    do_reset("t5b");
    req = 4'b1100;
    @(posedge clk);
    #1;
    chk("t5_grant", 32'(grant), 32'h4);
    chk("t5_idx", 32'(idx), 32'h2);
    chk("t5_busy", 32'(busy), 32'h1);

    // T6: one-cycle slots, no gap, strict alternation.
    do_reset("t6");
    req6 = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      o = ((k - 1) / 2) % 4;
      nm = $sformatf("t6_%0d", k);
      if (k % 2 == 1) begin
        chk({nm, "_grant"}, 32'(grant6), 32'(1 << o));
        chk({nm, "_busy"}, 32'(busy6), 1);
        chk({nm, "_se"}, 32'(se6), 0);
      end else begin
        chk({nm, "_grant"}, 32'(grant6), 0);
        chk({nm, "_busy"}, 32'(busy6), 0);
        chk({nm, "_se"}, 32'(se6), 1);
      end
      chk({nm, "_idx"}, 32'(idx6), 32'(o));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tc_slot_arbiter.md
Name: tc_slot_arbiter

Overview:
Round-robin time-slot arbiter that shares one downstream resource among NREQ requesters. Each grant is held for a fixed slot of SLOT_LEN cycles, or less if the owner releases early. A guard gap of GAP_LEN cycles follows each grant. Slot and gap timing use the tc package terminal-count convention (tcbits/tcstop), with terminal count on the counter MSB. The block sits in front of shared readout/config resources that need bounded, fair access.

Parameters:
NREQ, 4, number of requesters (>=2)
SLOT_LEN, 16, maximum grant length in cycles (>=1)
GAP_LEN, 2, forced idle cycles after each grant (>=0; 0 skips the GAP state)

Ports:
clk  input  1  system clock
rst_n  input  1  reset
req_i  input  NREQ  request per requester, level
release_i  input  NREQ  early release, sampled only for the current owner
grant_o  output  NREQ  one-hot grant, registered
grant_idx_o  output  $clog2(NREQ)  index of current/last owner, registered
busy_o  output  1  high when state is not IDLE
slot_end_o  output  1  one-cycle pulse on the first cycle after a grant drops

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: state IDLE, grant_o=0, grant_idx_o=0, busy_o=0, slot_end_o=0, counter=0, last-owner pointer=NREQ-1, so index 0 has top priority after reset. Reset mid-grant drops grant_o immediately, without waiting for a clock edge.
- Counter:
  - Width is tcbits(max(SLOT_LEN,GAP_LEN,1)).
  - The counter is loaded with tcstop(L) and increments every cycle of the timed state.
  - Terminal count is the MSB of the next count value. The state therefore lasts exactly L cycles.
- States:
  - IDLE: grant_o=0. Combinationally select the first asserted req_i, searching from pointer+1 with modulo-NREQ wrap.
    - If any request is found, at the clock edge: enter GRANT, set grant_o one-hot, set grant_idx_o, set pointer to the winner, load tcstop(SLOT_LEN).
    - If no request is found, stay in IDLE.
  - GRANT: grant_o is held. The grant ends on terminal count, or when release_i[grant_idx_o]=1 in this cycle; that cycle is the last grant cycle.
    - On the next edge: grant_o=0, slot_end_o=1 for one cycle.
    - Then enter GAP, loading tcstop(GAP_LEN), when GAP_LEN>0. Otherwise enter IDLE.
  - GAP: grant_o=0 for exactly GAP_LEN cycles, then IDLE.
- Grant-low cycles between consecutive slots = GAP_LEN+1, because the IDLE arbitration cycle is always present.
- Rules during GRANT:
  - The owner dropping req_i does not end the slot; only terminal count or release ends it.
  - release_i on non-owner bits is ignored.
  - release_i in IDLE or GAP is ignored.
  - Release coinciding with terminal count produces a single end; slot_end_o still pulses once.
- Requests arriving during GRANT or GAP are not queued. They are evaluated only in IDLE from the live req_i level.
- busy_o is high in GRANT and GAP.
- grant_idx_o holds its value after the grant drops, until the next grant.
- Latency: req_i asserted in IDLE at cycle t gives grant_o high from t+1.

Test Plan:
1. Defaults; req_i=0001 held continuously -> grant_o=0001 for 16 cycles, then 0 for 3 cycles, repeating; slot_end_o pulses on the first low cycle of each gap.
2. Defaults; req_i=1111 held -> grant order 0,1,2,3,0; each grant is 16 cycles with 3 low cycles between grants; grant_idx_o sequence is 0,1,2,3,0.
3. Defaults; req_i=0010 with release_i[1] pulsed on the 5th grant cycle -> grant_o=0010 for exactly 5 cycles, slot_end_o on the next cycle, busy_o high for 2 more cycles, then IDLE.
4. Defaults; owner 1, release_i=0100 pulsed and req_i[1] dropped mid-slot -> grant to requester 1 still lasts the full 16 cycles.
5. Defaults; async rst_n low between clock edges on grant cycle 7 -> grant_o=0 and busy_o=0 immediately, without a clock edge. After release with req_i=1100 -> grant goes to index 2 one cycle later (pointer reset).
6. SLOT_LEN=1, GAP_LEN=0, req_i=1111 -> each grant lasts 1 cycle, 1 low cycle between grants, round-robin order 0,1,2,3, slot_end_o pulses every second cycle.
